// File: rtl/ds_restoring_seq.sv
// Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor, one
// quotient bit per clock, with a start/stop handshake shared with the
// shift-add multiplier.
module ds_restoring_seq #(
    parameter int unsigned DW = 8
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [2*DW-1:0] i_dividend,
    input  logic [DW-1:0]   i_divisor,
    output logic [2*DW-1:0] o_quotient,
    output logic [DW-1:0]   o_remainder,
    output logic            o_stop,
    output logic            o_busy,
    output logic            o_div_by_zero
);

    localparam int unsigned QW = 2 * DW;
    localparam int unsigned CW = $clog2(QW + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [DW-1:0] rem_q, rem_nxt;   // partial remainder, always < divisor
    logic [QW-1:0] quo_sr, quo_sr_nxt;
    logic [DW-1:0] dvs_q, dvs_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [QW-1:0] quotient_nxt;
    logic [DW-1:0] remainder_nxt;
    logic          dbz_nxt;
    logic [DW:0]   trial;

    // State, datapath and registered outputs; reset overrides start.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state         <= S_IDLE;
            rem_q         <= '0;
            quo_sr        <= '0;
            dvs_q         <= '0;
            cnt           <= '0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
            o_stop        <= 1'b0;
            o_busy        <= 1'b0;
        end else begin
            state         <= state_nxt;
            rem_q         <= rem_nxt;
            quo_sr        <= quo_sr_nxt;
            dvs_q         <= dvs_nxt;
            cnt           <= cnt_nxt;
            o_quotient    <= quotient_nxt;
            o_remainder   <= remainder_nxt;
            o_div_by_zero <= dbz_nxt;
            o_stop        <= (state_nxt == S_DONE);
            o_busy        <= (state_nxt != S_IDLE);
        end
    end

    // Next-state and one restoring step per CALC cycle.
    always_comb begin
        state_nxt     = state;
        rem_nxt       = rem_q;
        quo_sr_nxt    = quo_sr;
        dvs_nxt       = dvs_q;
        cnt_nxt       = cnt;
        quotient_nxt  = o_quotient;
        remainder_nxt = o_remainder;
        dbz_nxt       = o_div_by_zero;
        // Shifted-in remainder minus divisor; the top bit is the borrow.
        trial = {rem_q, quo_sr[QW-1]} - {1'b0, dvs_q};

        case (state)
            S_IDLE: begin
                if (i_start) begin
                    if (i_divisor != '0) begin
                        dvs_nxt    = i_divisor;
                        rem_nxt    = '0;
                        quo_sr_nxt = i_dividend;
                        cnt_nxt    = CW'(QW);
                        state_nxt  = S_CALC;
                    end else begin
                        quotient_nxt  = '1;
                        remainder_nxt = '0;
                        dbz_nxt       = 1'b1;
                        state_nxt     = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (!trial[DW]) begin
                    rem_nxt    = trial[DW-1:0];
                    quo_sr_nxt = {quo_sr[QW-2:0], 1'b1};
                end else begin
                    rem_nxt    = {rem_q[DW-2:0], quo_sr[QW-1]};
                    quo_sr_nxt = {quo_sr[QW-2:0], 1'b0};
                end
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    quotient_nxt  = quo_sr_nxt;
                    remainder_nxt = rem_nxt;
                    dbz_nxt       = 1'b0;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
